// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync/blank
// decode with an optional pix_en-driven delay, plus line/frame strobes.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   pix_en      pixel strobe; all timing advances only when 1
//   pixelx      horizontal count, 0..H_TOTAL-1
//   pixely      vertical count, 0..V_TOTAL-1
//   hsync       horizontal sync, level set by HS_POL, DELAY strobes late
//   vsync       vertical sync, level set by VS_POL, DELAY strobes late
//   blank       1 during active video (blank_n style), DELAY strobes late
//   sync        tied to 1, composite sync is not used
//   line_start  one-clk pulse on the strobe that moves pixelx onto 0
//   frame_start one-clk pulse on the strobe that moves onto (0,0)
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DELAY    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] pixelx,
  output logic [CW-1:0] pixely,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // One extra bit so a sync end equal to 2^CW does not wrap to 0.
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic          x_last;
  logic          y_last;
  logic [CW:0]   x_ext;
  logic [CW:0]   y_ext;
  logic          hs_raw;
  logic          vs_raw;
  logic          act_raw;
  logic          hs_o;
  logic          vs_o;
  logic          bl_o;

  assign x_last = (pixelx == H_LAST);
  assign y_last = (pixely == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixelx      <= '0;
      pixely      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      pixelx      <= x_last ? '0 : pixelx + CW'(1);
      if (x_last)
        pixely    <= y_last ? '0 : pixely + CW'(1);
      line_start  <= x_last;
      frame_start <= x_last && y_last;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign x_ext   = {1'b0, pixelx};
  assign y_ext   = {1'b0, pixely};
  assign act_raw = (x_ext < H_ACT) && (y_ext < V_ACT);
  assign hs_raw  = (x_ext >= HS_BEG) && (x_ext < HS_END);
  assign vs_raw  = (y_ext >= VS_BEG) && (y_ext < VS_END);

  if (DELAY == 0) begin : g_nodly
    assign hs_o = hs_raw;
    assign vs_o = vs_raw;
    assign bl_o = act_raw;
  end else begin : g_dly
    // Each stage holds {hs, vs, active} in asserted-high form.
    logic [2:0] stg [DELAY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DELAY; i++)
          stg[i] <= 3'b000;
      end else if (pix_en) begin
        stg[0] <= {hs_raw, vs_raw, act_raw};
        for (int i = 1; i < DELAY; i++)
          stg[i] <= stg[i-1];
      end
    end

    assign hs_o = stg[DELAY-1][2];
    assign vs_o = stg[DELAY-1][1];
    assign bl_o = stg[DELAY-1][0];
  end

  // Gating with rst keeps the outputs inactive while reset is held,
  // even though the counters decode as active video at (0,0).
  assign hsync = HS_POL ? (hs_o & rst) : ~(hs_o & rst);
  assign vsync = VS_POL ? (vs_o & rst) : ~(vs_o & rst);
  assign blank = bl_o & rst;
  assign sync  = 1'b1;

endmodule
